mmu_async_rx_bridge: RTL and testbench
======================================

Name: mmu_async_rx_bridge

Overview:
- Downstream neighbour of the 5-port MMU arbiter-merge.
- Consumes its bundled-data drive/free stream: i_drive rising edge means i_data is valid; a free pulse lets the next item in.
- Crosses each item into the clocked MMU lookup domain through a toggle synchronizer and a small FIFO.
- Presents a valid/ready interface to the clocked pipeline.

Parameters:
DATA_WIDTH, 79, width of the merged request word
DEPTH, 4, FIFO entries; power of two, >=2
SYNC_STAGES, 2, flops in the request-toggle synchronizer; >=2

Ports:
clk  input  1  lookup-domain clock
rstn  input  1  reset, asynchronous, active-low
i_drive  input  1  upstream request; rising edge marks a new item
i_data  input  DATA_WIDTH  upstream data; stable from before the i_drive rising edge until o_free pulses
o_free  output  1  one-clk-cycle high pulse; releases upstream for the next item
o_valid  output  1  FIFO head valid
o_data  output  DATA_WIDTH  FIFO head data (first-word fall-through)
i_ready  input  1  downstream accepts head when o_valid & i_ready at posedge clk
o_count  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rstn low, async):
  - r_hold, r_req_tog, sync chain, r_ack_tog, pointers and count clear to 0.
  - o_free=0, o_valid=0, o_data=0, o_count=0.
  - Any captured-but-untransferred item is discarded.
  - No free token is issued at reset; upstream may drive immediately after rstn rises.
- Capture (async side):
  - On posedge i_drive: r_hold <= i_data and r_req_tog toggles.
  - Both flops use the i_drive edge as clock and rstn as async clear.
- Synchronize:
  - r_req_tog passes through SYNC_STAGES flops on clk; s_last is the final stage.
  - The pending condition is s_last != r_ack_tog.
- Transfer:
  - w_xfer = pending & ~full, evaluated each posedge clk.
  - On w_xfer: write r_hold at wr_ptr, advance wr_ptr modulo DEPTH, flip r_ack_tog, set o_free=1 for exactly one cycle.
  - Otherwise o_free=0.
- Read:
  - w_rd = o_valid & i_ready.
  - On w_rd, advance rd_ptr modulo DEPTH.
  - o_data is always mem[rd_ptr]; it holds the last value when empty and has no meaning then.
- Occupancy:
  - count += w_xfer - w_rd.
  - full = (count==DEPTH); o_valid = (count!=0).
  - A simultaneous write and read keeps count unchanged.
  - Write at full is blocked even if a read happens in the same cycle. The full check is not read-accelerated, so one cycle of write bubble is expected.
- Latency:
  - If the i_drive rising edge is sampled by s[0] at edge k, and the FIFO is not full, then o_free and o_valid (when previously empty) are high after edge k+SYNC_STAGES-1+1.
  - With SYNC_STAGES=2, that is 2 cycles after the sampling edge.
  - The end-to-end minimum is SYNC_STAGES clocks plus the upstream pulse path.
- Back-pressure:
  - While full and pending, o_free stays low and r_hold is retained.
  - The first cycle after count<DEPTH transfers the item.
- Protocol:
  - Upstream must not raise i_drive again before o_free has pulsed; violation is undefined and not checked.
  - At most one item is ever in flight between capture and FIFO.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; data order is strictly FIFO.
- Reset mid-operation:
  - All state clears asynchronously; o_free drops the same instant.
  - The upstream merge is reset by the same rstn, so no handshake is left dangling.

Test Plan:
- Single item: drive D=0x1234 with FIFO empty and i_ready=0 -> exactly one o_free pulse SYNC_STAGES edges after sampling; o_valid=1, o_data=0x1234, o_count=1.
- Fill and stall, DEPTH=4, i_ready=0:
  - Send 5 items A..E, each after the previous o_free -> 4 o_free pulses, o_count=4, no 5th pulse while E is held.
  - Raise i_ready for one cycle -> A is popped; one cycle later E is written and o_free pulses.
- Ordering/wrap: i_ready=1, send 10 items 0..9 back-to-back -> o_data sequence 0..9 in order; pointers wrap twice; o_count never exceeds 1.
- Simultaneous read/write at o_count=2 -> o_count remains 2 and the head advances to the next item.
- Reset mid-operation: assert rstn low after capture, before the o_free pulse -> o_free=0, o_valid=0, o_count=0 immediately. After release, a new item is received correctly and the discarded one never appears.
- Random ready toggling with 200 items (scoreboard) -> no loss, no duplication, order preserved, one o_free per item.

Source files
------------

// File: rtl/mmu_async_rx_bridge.sv
// mmu_async_rx_bridge: receives the bundled-data drive/free stream and hands items to the clk domain through a toggle synchronizer and a FWFT FIFO
module mmu_async_rx_bridge #(
    parameter int DATA_WIDTH  = 79,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_drive,
    input  logic [DATA_WIDTH-1:0]        i_data,
    output logic                         o_free,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0]  r_hold;
    logic                   r_req_tog;
    logic                   r_ack_tog;
    logic [SYNC_STAGES-1:0] s;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   pending;
    logic                   full;
    logic                   w_xfer;
    logic                   w_rd;

    assign pending = s[SYNC_STAGES-1] ^ r_ack_tog;
    assign full    = o_count == CW'(DEPTH);
    assign w_xfer  = pending & ~full;
    assign o_valid = o_count != '0;
    assign w_rd    = o_valid & i_ready;
    assign o_data  = mem[rd_ptr];

    // capture the upstream word and flag it by toggling the request on the drive edge
    always_ff @(posedge i_drive or negedge rstn)
        if (!rstn) begin
            r_hold    <= '0;
            r_req_tog <= 1'b0;
        end else begin
            r_hold    <= i_data;
            r_req_tog <= ~r_req_tog;
        end

    // bring the request toggle into the clk domain
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) s <= '0;
        else s <= {s[SYNC_STAGES-2:0], r_req_tog};

    // accept the held item when room exists, release upstream, track pointers and occupancy
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            r_ack_tog <= 1'b0;
            o_free    <= 1'b0;
            o_count   <= '0;
        end else begin
            o_free  <= w_xfer;
            wr_ptr  <= w_xfer ? wr_ptr + AW'(1) : wr_ptr;
            r_ack_tog <= r_ack_tog ^ w_xfer;
            rd_ptr  <= w_rd ? rd_ptr + AW'(1) : rd_ptr;
            o_count <= o_count + CW'(w_xfer) - CW'(w_rd);
        end

    // storage is cleared so the head reads zero out of reset
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (w_xfer) begin
            mem[wr_ptr] <= r_hold;
        end
endmodule

// File: tb/tb_mmu_async_rx_bridge.sv
// tb_mmu_async_rx_bridge: directed and scoreboard checks of the async receive bridge
module tb_mmu_async_rx_bridge;
    localparam int DW = 79;

    logic          clk;
    logic          rstn;
    logic          i_drive;
    logic [DW-1:0] i_data;
    logic          o_free;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic [2:0]    o_count;

    int checks;
    int errors;
    int free_cnt;
    int over1_cnt;
    bit rand_ready;
    logic [DW-1:0] popped[$];

    mmu_async_rx_bridge #(.DATA_WIDTH(DW), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_data(i_data),
        .o_free(o_free), .o_valid(o_valid), .o_data(o_data),
        .i_ready(i_ready), .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observe pulses and pops away from the active edge
    always @(negedge clk)
        if (rstn) begin
            if (o_free) free_cnt++;
            if (o_valid && i_ready) popped.push_back(o_data);
            if (o_count > 3'd1) over1_cnt++;
        end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_drive = 1'b0;
        i_ready = 1'b0;
        i_data = '0;
        rand_ready = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic send_item(input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        i_data = d;
        i_drive = 1'b1;
        step();
        i_drive = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (o_free) got = 1'b1;
            else step();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_item: no o_free for data %0h", d);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        i_drive = 1'b0;
        i_ready = 1'b0;
        i_data = '0;
        step();
        chk("reset o_free", DW'(o_free), 0);
        chk("reset o_valid", DW'(o_valid), 0);
        chk("reset o_count", DW'(o_count), 0);
        chk("reset o_data", o_data, 0);
        rstn = 1'b1;
        step();
        step();
        chk("post-reset o_free", DW'(o_free), 0);
        chk("post-reset o_valid", DW'(o_valid), 0);
    endtask

    task automatic test_single();
        do_reset();
        i_data = DW'(16'h1234);
        i_drive = 1'b1;
        step();
        i_drive = 1'b0;
        chk("single free e1", DW'(o_free), 0);
        step();
        chk("single free e2", DW'(o_free), 0);
        chk("single valid e2", DW'(o_valid), 0);
        step();
        chk("single free e3", DW'(o_free), 1);
        chk("single valid e3", DW'(o_valid), 1);
        chk("single data", o_data, DW'(16'h1234));
        chk("single count", DW'(o_count), 1);
        step();
        chk("single free e4", DW'(o_free), 0);
        chk("single count e4", DW'(o_count), 1);
    endtask

    task automatic test_fill_stall();
        logic [DW-1:0] v [5];
        bit saw;
        int fb;
        v[0] = DW'(32'hA0A0_0001);
        v[1] = DW'(32'hB0B0_0002);
        v[2] = DW'(32'hC0C0_0003);
        v[3] = DW'(32'hD0D0_0004);
        v[4] = DW'(32'hE0E0_0005);
        do_reset();
        fb = free_cnt;
        for (int i = 0; i < 4; i++) send_item(v[i]);
        chk("fill count", DW'(o_count), 4);
        i_data = v[4];
        i_drive = 1'b1;
        step();
        i_drive = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_free) saw = 1'b1;
            step();
        end
        chk("stall no free", DW'(saw), 0);
        chk("stall count", DW'(o_count), 4);
        chk("stall head", o_data, v[0]);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk("bubble free", DW'(o_free), 0);
        chk("bubble count", DW'(o_count), 3);
        chk("bubble head", o_data, v[1]);
        step();
        chk("refill free", DW'(o_free), 1);
        chk("refill count", DW'(o_count), 4);
        i_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("drain head", o_data, v[i]);
            step();
        end
        i_ready = 1'b0;
        chk("drain valid", DW'(o_valid), 0);
        chk("drain count", DW'(o_count), 0);
        chk("fill free pulses", DW'(free_cnt - fb), 5);
    endtask

    task automatic test_order_wrap();
        int pb;
        int fb;
        int ob;
        do_reset();
        pb = popped.size();
        fb = free_cnt;
        ob = over1_cnt;
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_item(DW'(i));
        step();
        step();
        step();
        chk("order pop count", DW'(popped.size() - pb), 10);
        for (int i = 0; i < 10 && pb + i < popped.size(); i++) chk("order data", popped[pb + i], DW'(i));
        chk("order count<=1", DW'(over1_cnt - ob), 0);
        chk("order free pulses", DW'(free_cnt - fb), 10);
        chk("order empty", DW'(o_valid), 0);
        i_ready = 1'b0;
    endtask

    task automatic test_simul_rw();
        do_reset();
        send_item(DW'(32'h5500));
        send_item(DW'(32'h5501));
        step();
        chk("simul pre count", DW'(o_count), 2);
        i_data = DW'(32'h5502);
        i_drive = 1'b1;
        step();
        i_drive = 1'b0;
        step();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk("simul free", DW'(o_free), 1);
        chk("simul count", DW'(o_count), 2);
        chk("simul head", o_data, DW'(32'h5501));
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk("simul next head", o_data, DW'(32'h5502));
        chk("simul next count", DW'(o_count), 1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_item(DW'(32'h7700));
        step();
        chk("mid pre valid", DW'(o_valid), 1);
        i_data = DW'(32'h7701);
        i_drive = 1'b1;
        step();
        #3;
        rstn = 1'b0;
        i_drive = 1'b0;
        #1;
        chk("mid free", DW'(o_free), 0);
        chk("mid valid", DW'(o_valid), 0);
        chk("mid count", DW'(o_count), 0);
        step();
        step();
        rstn = 1'b1;
        step();
        step();
        step();
        chk("mid discard count", DW'(o_count), 0);
        send_item(DW'(32'h7702));
        chk("mid new data", o_data, DW'(32'h7702));
        chk("mid new count", DW'(o_count), 1);
        step();
        step();
        step();
        step();
        chk("mid no ghost", DW'(o_count), 1);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        send_item(DW'(32'h7703));
        rstn = 1'b0;
        #1;
        chk("mid free drop", DW'(o_free), 0);
        chk("mid free drop count", DW'(o_count), 0);
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] d;
        int pb;
        int fb;
        int bad;
        do_reset();
        pb = popped.size();
        fb = free_cnt;
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            d = {15'(i), 32'($urandom), 32'($urandom)};
            exp_q.push_back(d);
            send_item(d);
        end
        rand_ready = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 20 && o_valid; n++) step();
        step();
        i_ready = 1'b0;
        chk("random pop count", DW'(popped.size() - pb), 200);
        chk("random free pulses", DW'(free_cnt - fb), 200);
        bad = 0;
        for (int i = 0; i < 200 && pb + i < popped.size(); i++)
            if (popped[pb + i] !== exp_q[i]) bad++;
        chk("random order mismatches", DW'(bad), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        free_cnt = 0;
        over1_cnt = 0;
        rand_ready = 1'b0;
        rstn = 1'b0;
        i_drive = 1'b0;
        i_ready = 1'b0;
        i_data = '0;
        test_reset();
        test_single();
        test_fill_stall();
        test_order_wrap();
        test_simul_rw();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
